// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory arbiter FSM state and bus owner encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DATA_BUSY  = 2'd1,
    INSTR_BUSY = 2'd2,
    RESP       = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates fetch and memory-stage requests onto one single-ported memory bus,
// with data priority, a fetch starvation guard and a bus timeout.
module pipe_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              timeout_err
);

  localparam int unsigned STARVE_W = cnt_width(STARVE_LIMIT);
  localparam int unsigned WAIT_W   = cnt_width(TIMEOUT_CYC);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT_CYC - 1);

  arb_state_e          state_q;
  owner_e              owner_q;
  logic [STARVE_W-1:0] starve_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                bus_req_q;
  logic                bus_we_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic                if_valid_q;
  logic                mem_done_q;
  logic                timeout_err_q;

  logic                grant_data_d;
  logic                timeout_d;
  logic [STARVE_W-1:0] starve_inc_d;
  logic [DATA_W-1:0]   result_d;

  // Arbitration and completion decisions for the current cycle.
  always_comb begin
    grant_data_d = mem_req && (!if_req || (starve_cnt_q < STARVE_MAX));
    timeout_d    = !bus_ack && (wait_cnt_q == WAIT_LAST);
    starve_inc_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                : starve_cnt_q + STARVE_W'(1);
    // Stores and aborted transactions report zero data.
    result_d     = '0;
    if (bus_ack && !((owner_q == OWN_DATA) && bus_we_q)) begin
      result_d = bus_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_INSTR;
      starve_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      if_rdata_q    <= '0;
      mem_rdata_q   <= '0;
      if_valid_q    <= 1'b0;
      mem_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (grant_data_d) begin
            state_q     <= DATA_BUSY;
            owner_q     <= OWN_DATA;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
            if (if_req) begin
              starve_cnt_q <= starve_inc_d;
            end
          end else if (if_req) begin
            state_q      <= INSTR_BUSY;
            owner_q      <= OWN_INSTR;
            bus_req_q    <= 1'b1;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= if_addr;
            bus_wdata_q  <= '0;
            starve_cnt_q <= '0;
          end
        end
        DATA_BUSY, INSTR_BUSY: begin
          if (bus_ack || timeout_d) begin
            state_q    <= RESP;
            bus_req_q  <= 1'b0;
            wait_cnt_q <= '0;
            if (!bus_ack) begin
              timeout_err_q <= 1'b1;
            end
            if (owner_q == OWN_DATA) begin
              mem_rdata_q <= result_d;
              mem_done_q  <= 1'b1;
            end else begin
              if_rdata_q <= result_d;
              if_valid_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_valid    = if_valid_q;
  assign mem_done    = mem_done_q;
  assign timeout_err = timeout_err_q;

  // Stalls follow the live request so the pipeline freezes in the same cycle.
  assign stall_if  = if_req && !if_valid_q;
  assign stall_mem = mem_req && !mem_done_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: requester agents and a bus responder
// drive directed transactions; a monitor checks every completion pulse.
module tb_pipe_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        timeout_err;

  pipe_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYC(64)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mcmd_t;

  exp_t        exp_if[$];
  exp_t        exp_mem[$];
  logic [31:0] fetch_cmds[$];
  mcmd_t       mem_cmds[$];

  int n_checks  = 0;
  int n_err     = 0;
  int cyc       = 0;
  bit ack_en    = 1'b0;
  int ack_lat   = 0;
  bit abort_mem = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Memory contents seen by the bus responder.
  function automatic logic [31:0] bus_fn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C22_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    return e;
  endfunction

  function automatic mcmd_t mk_mcmd(input logic we, input logic [31:0] a, input logic [31:0] wd);
    mcmd_t m;
    m.we    = we;
    m.addr  = a;
    m.wdata = wd;
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (((exp_if.size() + exp_mem.size()) != 0 || if_req || mem_req) && n < 300) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 300) begin
      n_err++;
      $display("FAIL %s_drain: %0d fetch and %0d data completions still outstanding after 300 cycles",
               name, exp_if.size(), exp_mem.size());
    end
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check1({tag, "_bus_req"},     bus_req,     1'b0);
    check1({tag, "_bus_we"},      bus_we,      1'b0);
    check ({tag, "_bus_addr"},    bus_addr,    32'h0);
    check ({tag, "_bus_wdata"},   bus_wdata,   32'h0);
    check1({tag, "_if_valid"},    if_valid,    1'b0);
    check ({tag, "_if_rdata"},    if_rdata,    32'h0);
    check1({tag, "_mem_done"},    mem_done,    1'b0);
    check ({tag, "_mem_rdata"},   mem_rdata,   32'h0);
    check1({tag, "_stall_if"},    stall_if,    1'b0);
    check1({tag, "_stall_mem"},   stall_mem,   1'b0);
    check1({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  // Bus slave: acks ack_lat cycles after bus_req rises.
  initial begin : bus_responder
    int wait_n;
    wait_n    = 0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      bus_ack = 1'b0;
      if (bus_req && ack_en && !reset) begin
        if (wait_n >= ack_lat) begin
          bus_ack   = 1'b1;
          bus_rdata = bus_fn(bus_addr);
          wait_n    = 0;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  // Fetch requester: holds if_req until if_valid, then issues the next queued address.
  initial begin : fetch_agent
    if_req  = 1'b0;
    if_addr = '0;
    forever begin
      @(posedge clock);
      #1;
      if (if_req && if_valid) if_req = 1'b0;
      if (!if_req && fetch_cmds.size() > 0) begin
        if_addr = fetch_cmds.pop_front();
        if_req  = 1'b1;
      end
    end
  end

  // Data requester: same handshake on mem_req/mem_done.
  initial begin : mem_agent
    mcmd_t m;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (abort_mem) begin
        mem_req = 1'b0;
      end else begin
        if (mem_req && mem_done) mem_req = 1'b0;
        if (!mem_req && mem_cmds.size() > 0) begin
          m         = mem_cmds.pop_front();
          mem_we    = m.we;
          mem_addr  = m.addr;
          mem_wdata = m.wdata;
          mem_req   = 1'b1;
        end
      end
    end
  end

  // Completion monitor: every pulse must match the head of its queue in data and cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (if_valid) begin
        if (exp_if.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL if_valid_unexpected: pulse with if_rdata 0x%08h, none expected (cycle %0d)", if_rdata, cyc);
        end else begin
          e = exp_if.pop_front();
          check("if_rdata", if_rdata, e.data);
          check("if_valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_done) begin
        if (exp_mem.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL mem_done_unexpected: pulse with mem_rdata 0x%08h, none expected (cycle %0d)", mem_rdata, cyc);
        end else begin
          e = exp_mem.pop_front();
          check("mem_rdata", mem_rdata, e.data);
          check("mem_done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c0;
    reset = 1'b1;
    repeat (3) step();
    check_idle_outputs("por");
    reset = 1'b0;
    step();

    // Lone fetch, ack in the third bus cycle.
    ack_en  = 1'b1;
    ack_lat = 2;
    c0 = cyc + 1;
    fetch_cmds.push_back(32'h40);
    exp_if.push_back(mk_exp(32'h8C22_0004, c0 + 4));
    wait_until(c0);
    check1("t1_stall_if_c0", stall_if, 1'b1);
    check1("t1_bus_req_c0", bus_req, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check1("t1_bus_req", bus_req, 1'b1);
      check ("t1_bus_addr", bus_addr, 32'h40);
      check1("t1_bus_we", bus_we, 1'b0);
      check1("t1_stall_if", stall_if, 1'b1);
    end
    step();
    check1("t1_bus_req_drop", bus_req, 1'b0);
    drain("t1");

    // Simultaneous store and fetch: data first, fetch after RESP.
    ack_lat = 0;
    c0 = cyc + 1;
    mem_cmds.push_back(mk_mcmd(1'b1, 32'h100, 32'hDEAD_BEEF));
    fetch_cmds.push_back(32'h44);
    exp_mem.push_back(mk_exp(32'h0, c0 + 2));
    exp_if.push_back(mk_exp(bus_fn(32'h44), c0 + 5));
    wait_until(c0 + 1);
    check1("t2_bus_we", bus_we, 1'b1);
    check ("t2_bus_addr", bus_addr, 32'h100);
    check ("t2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    check1("t2_stall_if_busy", stall_if, 1'b1);
    check1("t2_stall_mem_busy", stall_mem, 1'b1);
    wait_until(c0 + 2);
    check1("t2_stall_if_resp", stall_if, 1'b1);
    wait_until(c0 + 3);
    check1("t2_stall_if_idle", stall_if, 1'b1);
    check1("t2_bus_req_idle", bus_req, 1'b0);
    wait_until(c0 + 4);
    check ("t2_fetch_addr", bus_addr, 32'h44);
    check1("t2_fetch_we", bus_we, 1'b0);
    check1("t2_stall_if_fetch", stall_if, 1'b1);
    drain("t2");

    // Six back-to-back loads against a waiting fetch: fetch wins the 5th grant.
    c0 = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      mem_cmds.push_back(mk_mcmd(1'b0, 32'h200 + 32'(4 * i), 32'h0));
    end
    fetch_cmds.push_back(32'h80);
    fetch_cmds.push_back(32'h84);
    exp_mem.push_back(mk_exp(bus_fn(32'h200), c0 + 2));
    exp_mem.push_back(mk_exp(bus_fn(32'h204), c0 + 5));
    exp_mem.push_back(mk_exp(bus_fn(32'h208), c0 + 8));
    exp_mem.push_back(mk_exp(bus_fn(32'h20C), c0 + 11));
    exp_mem.push_back(mk_exp(bus_fn(32'h210), c0 + 17));
    exp_mem.push_back(mk_exp(bus_fn(32'h214), c0 + 20));
    exp_if.push_back(mk_exp(bus_fn(32'h80), c0 + 14));
    exp_if.push_back(mk_exp(bus_fn(32'h84), c0 + 23));
    wait_until(c0 + 13);
    check ("t3_fifth_grant_addr", bus_addr, 32'h80);
    check1("t3_fifth_grant_we", bus_we, 1'b0);
    wait_until(c0 + 16);
    check ("t3_sixth_grant_addr", bus_addr, 32'h210);
    drain("t3");

    // Dead bus: abort after 64 wait cycles.
    ack_en = 1'b0;
    c0 = cyc + 1;
    mem_cmds.push_back(mk_mcmd(1'b0, 32'h300, 32'h0));
    exp_mem.push_back(mk_exp(32'h0, c0 + 65));
    wait_until(c0 + 64);
    check1("t4_bus_req_last", bus_req, 1'b1);
    check1("t4_timeout_err_before", timeout_err, 1'b0);
    step();
    check1("t4_bus_req_abort", bus_req, 1'b0);
    check1("t4_timeout_err_set", timeout_err, 1'b1);
    drain("t4");
    repeat (5) step();
    check1("t4_timeout_err_sticky", timeout_err, 1'b1);

    // Reset in the middle of a data transaction drops it silently.
    c0 = cyc + 1;
    mem_cmds.push_back(mk_mcmd(1'b0, 32'h400, 32'h0));
    wait_until(c0 + 1);
    check1("t5_bus_req_busy", bus_req, 1'b1);
    abort_mem = 1'b1;
    wait_until(c0 + 2);
    check1("t5_bus_req_before_reset", bus_req, 1'b1);
    reset = 1'b1;
    wait_until(c0 + 3);
    check_idle_outputs("t5_reset");
    reset     = 1'b0;
    abort_mem = 1'b0;
    repeat (3) step();
    ack_en  = 1'b1;
    ack_lat = 1;
    c0 = cyc + 1;
    fetch_cmds.push_back(32'h48);
    exp_if.push_back(mk_exp(bus_fn(32'h48), c0 + 3));
    drain("t5");

    // Back-to-back fetches with an immediate ack: one every 3 cycles.
    ack_lat = 0;
    c0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      fetch_cmds.push_back(32'h500 + 32'(4 * i));
      exp_if.push_back(mk_exp(bus_fn(32'h500 + 32'(4 * i)), c0 + 2 + 3 * i));
    end
    drain("t6");

    check("sb_if_empty", 32'(exp_if.size()), 32'h0);
    check("sb_mem_empty", 32'(exp_mem.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
